ccip_mmio_csr_responder: RTL and testbench
==========================================

Name: ccip_mmio_csr_responder

Overview:
- Slave MMIO CSR block inside the AFU. It sits directly downstream of the CCI-P Rx port (c0 MMIO requests) and upstream of the Tx c2 response channel.
- Decodes host MMIO reads and writes against a fixed AFU register map: DFH, AFU ID, status, counters and scratch registers.
- Returns every read response at fixed latency; c2 has no backpressure.
- Exports scratch register 0 as the AFU control word.

Parameters:
- AFU_ID, 128'h0, value returned at AFU_ID_L (low 64 bits) and AFU_ID_H (high 64 bits).
- DFH_VALUE, 64'h1000_0100_0000_0000, AFU DFH: type=1 in [63:60], EOL in bit 40.
- NUM_SCRATCH, 4, number of 64-bit scratch registers; legal range 1..8.

Ports:
- pClk  in  1  CCI-P primary clock; all logic on rising edge.
- pck_cp2af_softReset  in  1  synchronous, active-high reset.
- mmio_rd_valid  in  1  c0 mmioRdValid.
- mmio_wr_valid  in  1  c0 mmioWrValid.
- mmio_addr  in  16  MMIO address in 4-byte word units.
- mmio_len  in  2  0 = 4B access, 1 = 8B access, other values unused.
- mmio_tid  in  9  read transaction ID.
- mmio_wr_data  in  64  write data.
- csr_status  in  64  read-only status from the AFU.
- mmio_rsp_valid  out  1  c2 mmioRdValid.
- mmio_rsp_tid  out  9  echoed TID.
- mmio_rsp_data  out  64  read data.
- csr_ctrl  out  64  live value of SCRATCH0.

Behaviour:
- Register map (byte offset; word address = byte >> 2):
  - 0x00 DFH, RO.
  - 0x08 AFU_ID_L, RO.
  - 0x10 AFU_ID_H, RO.
  - 0x18 NEXT_AFU, RO, reads 0.
  - 0x20 RSVD, RO, reads 0.
  - 0x28 STATUS, RO, reads csr_status.
  - 0x30 CYCLE, RO: 64-bit free-running count, +1 per pClk, wraps to 0.
  - 0x38 WR_COUNT, RO: [31:0] count of accepted writes to SCRATCH registers, saturating at FFFF_FFFF; [63:32] = 0.
  - 0x40 + 8*i SCRATCH i, RW, for i < NUM_SCRATCH.
  - Every other offset is unmapped: reads return 0, writes are ignored.
- Reset values:
  - mmio_rsp_valid = 0, mmio_rsp_tid = 0, mmio_rsp_data = 0.
  - All scratch registers, CYCLE and WR_COUNT = 0, so csr_ctrl = 0.
- Reset is synchronous and applies while pck_cp2af_softReset is high, including mid-operation. Reads in flight are dropped and never responded to.
- Read pipeline:
  - Stage 1 captures tid and the muxed read data at the edge after the request (cycle T).
  - Stage 2 drives the response, so mmio_rsp_valid is high in cycle T+2 for exactly one cycle.
  - Back-to-back reads every cycle produce back-to-back responses in order.
- Read data rules:
  - 8B read at even word address returns the full 64-bit register.
  - 4B read at even word address returns reg[31:0] in data[31:0]; upper bits are 0.
  - 4B read at odd word address returns reg[63:32] in data[31:0]; upper bits are 0.
  - 8B read at odd word address returns 0.
  - A response is always produced, including for unmapped addresses.
- Write rules:
  - 8B write at even word address writes all 64 bits.
  - 4B write writes the half selected by addr[0], taking data from mmio_wr_data[31:0].
  - 8B write at odd address is ignored.
  - WR_COUNT increments only for writes that modify a SCRATCH register.
- Ordering:
  - A write in cycle T takes effect at the edge ending T. A read in cycle T+1 sees the new value.
  - If rd and wr are both valid in the same cycle, both are processed and the read returns the pre-write value.
- CYCLE is sampled into stage 1, so it reads as the count at cycle T.

Optional Feature:
- Macro: MMIO_ERR_LOG_EN.
- Defined: register ERR_LOG at 0x80.
  - [63:48] = saturating count of unmapped reads or writes.
  - [15:0] = word address of the most recent unmapped access.
  - Any 4B or 8B write to ERR_LOG clears it to 0; that write is not itself logged.
  - Reset value is 0.
- Not defined: 0x80 is unmapped, and no logic is instantiated.

Test Plan:
- Reset, then 8B read of word 0x0000 with tid 0x1A5 -> response 2 cycles later: tid 0x1A5, data 64'h1000_0100_0000_0000, valid high for exactly 1 cycle.
- 8B write of 64'hDEAD_BEEF_0123_4567 to 0x40, then 4B reads of words 0x10 and 0x11 -> data 32'h0123_4567 then 32'hDEAD_BEEF; csr_ctrl = DEAD_BEEF_0123_4567; WR_COUNT = 1.
- 4B write of 32'hA5A5_A5A5 to word 0x13 (SCRATCH1 upper half) and an 8B read of 0x48 in the same cycle -> read returns 0; the next read returns 64'hA5A5_A5A5_0000_0000.
- Reads on 16 consecutive cycles with tids 0..15 to mixed mapped and unmapped addresses -> 16 consecutive responses in tid order; unmapped ones return 0.
- Read issued, then softReset asserted in the following cycle -> no response appears; csr_ctrl = 0 and CYCLE restarts from 0.
- With MMIO_ERR_LOG_EN: 3 reads of word 0x0100 -> ERR_LOG = 64'h0003_0000_0000_0100; a write to 0x80 -> ERR_LOG = 0.

Source files
------------

// File: rtl/ccip_mmio_csr_responder_if.sv
// ccip_mmio_csr_responder_if: CCI-P c0 MMIO request and c2 read-response signal bundle
interface ccip_mmio_csr_responder_if;
    logic        mmio_rd_valid;
    logic        mmio_wr_valid;
    logic [15:0] mmio_addr;
    logic [1:0]  mmio_len;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_wr_data;
    logic        mmio_rsp_valid;
    logic [8:0]  mmio_rsp_tid;
    logic [63:0] mmio_rsp_data;
    modport master (
        output mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len, mmio_tid, mmio_wr_data,
        input  mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
    );
    modport slave (
        input  mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len, mmio_tid, mmio_wr_data,
        output mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
    );
endinterface

// File: rtl/ccip_mmio_csr_responder.sv
// ccip_mmio_csr_responder: AFU MMIO CSR map with 2-cycle read responses; MMIO_ERR_LOG_EN adds ERR_LOG at 0x80
module ccip_mmio_csr_responder #(
    parameter logic [127:0] AFU_ID      = 128'h0,
    parameter logic [63:0]  DFH_VALUE   = 64'h1000_0100_0000_0000,
    parameter int           NUM_SCRATCH = 4
) (
    input  logic                            pClk,
    input  logic                            pck_cp2af_softReset,
    ccip_mmio_csr_responder_if.slave        mmio,
    input  logic [63:0]                     csr_status,
    output logic [63:0]                     csr_ctrl
);
    logic [14:0] qw;
    logic        odd;
    logic        is8;
    logic [63:0] scratch [NUM_SCRATCH];
    logic [63:0] cycle_cnt;
    logic [31:0] wr_count;
    logic [63:0] reg_val;
    logic [63:0] rd_data;
    logic        mapped;
    logic        scr_wr;
    logic        s1_valid;
    logic [8:0]  s1_tid;
    logic [63:0] s1_data;
`ifdef MMIO_ERR_LOG_EN
    logic [15:0] err_cnt;
    logic [15:0] err_addr;
    logic        err_hit;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;
`endif

    assign qw       = mmio.mmio_addr[15:1];
    assign odd      = mmio.mmio_addr[0];
    assign is8      = mmio.mmio_len == 2'd1;
    assign csr_ctrl = scratch[0];

    always_comb begin
        reg_val = '0;
        mapped  = 1'b1;
        case (qw)
            15'd0:   reg_val = DFH_VALUE;
            15'd1:   reg_val = AFU_ID[63:0];
            15'd2:   reg_val = AFU_ID[127:64];
            15'd3:   reg_val = '0;
            15'd4:   reg_val = '0;
            15'd5:   reg_val = csr_status;
            15'd6:   reg_val = cycle_cnt;
            15'd7:   reg_val = {32'h0, wr_count};
`ifdef MMIO_ERR_LOG_EN
            15'h10:  reg_val = {err_cnt, 32'h0, err_addr};
`endif
            default: mapped = 1'b0;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++)
            if (qw == 15'(8 + i)) begin
                reg_val = scratch[i];
                mapped  = 1'b1;
            end
        // 4B reads return the addressed half right-justified; 8B reads need an even word address
        rd_data = is8 ? (odd ? 64'h0 : reg_val) : {32'h0, odd ? reg_val[63:32] : reg_val[31:0]};
        scr_wr  = mmio.mmio_wr_valid && qw >= 15'd8 && qw < 15'(8 + NUM_SCRATCH) && !(is8 && odd);
    end

    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
            cycle_cnt           <= '0;
            wr_count            <= '0;
            s1_valid            <= 1'b0;
            s1_tid              <= '0;
            s1_data             <= '0;
            mmio.mmio_rsp_valid <= 1'b0;
            mmio.mmio_rsp_tid   <= '0;
            mmio.mmio_rsp_data  <= '0;
        end else begin
            cycle_cnt           <= cycle_cnt + 64'd1;
            s1_valid            <= mmio.mmio_rd_valid;
            s1_tid              <= mmio.mmio_tid;
            s1_data             <= rd_data;
            mmio.mmio_rsp_valid <= s1_valid;
            mmio.mmio_rsp_tid   <= s1_tid;
            mmio.mmio_rsp_data  <= s1_data;
            if (scr_wr && wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
            for (int i = 0; i < NUM_SCRATCH; i++)
                if (scr_wr && qw == 15'(8 + i)) begin
                    if (is8) scratch[i] <= mmio.mmio_wr_data;
                    else if (odd) scratch[i][63:32] <= mmio.mmio_wr_data[31:0];
                    else scratch[i][31:0] <= mmio.mmio_wr_data[31:0];
                end
        end
    end

`ifdef MMIO_ERR_LOG_EN
    // rd and wr share one address, so a dual unmapped access counts twice
    assign err_hit = qw == 15'h10;
    assign err_inc = {1'b0, mmio.mmio_rd_valid && !mapped} + {1'b0, mmio.mmio_wr_valid && !mapped};
    assign err_sum = {1'b0, err_cnt} + {15'h0, err_inc};

    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset || (mmio.mmio_wr_valid && err_hit)) begin
            err_cnt  <= '0;
            err_addr <= '0;
        end else if (err_inc != 2'd0) begin
            err_cnt  <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            err_addr <= mmio.mmio_addr;
        end
    end
`endif
endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// tb_ccip_mmio_csr_responder: scoreboard bench for the MMIO CSR responder
module tb_ccip_mmio_csr_responder;
    localparam logic [127:0] ID  = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
    localparam logic [63:0]  DFH = 64'h1000_0100_0000_0000;
    localparam logic [63:0]  STS = 64'hCAFE_F00D_1234_5678;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] csr_status = STS;
    logic [63:0] csr_ctrl;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_rsp = 0;
    exp_t        q[$];

    ccip_mmio_csr_responder_if bus ();

    ccip_mmio_csr_responder #(.AFU_ID(ID), .DFH_VALUE(DFH), .NUM_SCRATCH(4)) dut (
        .pClk(clk),
        .pck_cp2af_softReset(rst),
        .mmio(bus),
        .csr_status(csr_status),
        .csr_ctrl(csr_ctrl)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mmio_rsp_valid) begin
            n_rsp++;
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: tid=%h data=%h, no response was expected", bus.mmio_rsp_tid, bus.mmio_rsp_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.mmio_rsp_tid !== e.tid || bus.mmio_rsp_data !== e.data || cyc != e.due) begin
                    n_err++;
                    $display("FAIL rsp: got tid=%h data=%h cyc=%0d, want tid=%h data=%h cyc=%0d",
                             bus.mmio_rsp_tid, bus.mmio_rsp_data, cyc, e.tid, e.data, e.due);
                end
            end
        end
    end

    task automatic req(input logic rv, input logic wv, input logic [15:0] a, input logic [1:0] l,
                       input logic [8:0] t, input logic [63:0] wd, input logic [63:0] exp);
        @(negedge clk);
        bus.mmio_rd_valid = rv;
        bus.mmio_wr_valid = wv;
        bus.mmio_addr     = a;
        bus.mmio_len      = l;
        bus.mmio_tid      = t;
        bus.mmio_wr_data  = wd;
        if (rv) q.push_back('{t, exp, cyc + 2});
    endtask

    task automatic rd(input logic [15:0] a, input logic [1:0] l, input logic [8:0] t, input logic [63:0] exp);
        req(1'b1, 1'b0, a, l, t, 64'h0, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [1:0] l, input logic [63:0] wd);
        req(1'b0, 1'b1, a, l, 9'h0, wd, 64'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.mmio_rd_valid = 1'b0;
            bus.mmio_wr_valid = 1'b0;
        end
    endtask

    task automatic drain;
        int k = 0;
        idle(1);
        while (q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d responses outstanding, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset;
        bus.mmio_rd_valid = 1'b0;
        bus.mmio_wr_valid = 1'b0;
        bus.mmio_addr     = '0;
        bus.mmio_len      = '0;
        bus.mmio_tid      = '0;
        bus.mmio_wr_data  = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.mmio_rsp_valid, bus.mmio_rsp_tid, bus.mmio_rsp_data, csr_ctrl} !== 138'h0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b tid=%h data=%h ctrl=%h, want all 0",
                     bus.mmio_rsp_valid, bus.mmio_rsp_tid, bus.mmio_rsp_data, csr_ctrl);
        end
        rst = 1'b0;
    endtask

    task automatic test_ro_regs;
        rd(16'h0000, 2'd1, 9'h1A5, DFH);
        idle(4);
        rd(16'h0002, 2'd1, 9'h001, ID[63:0]);
        rd(16'h0004, 2'd1, 9'h002, ID[127:64]);
        rd(16'h0005, 2'd0, 9'h003, {32'h0, ID[127:96]});
        rd(16'h0004, 2'd0, 9'h004, {32'h0, ID[95:64]});
        rd(16'h0001, 2'd1, 9'h005, 64'h0);
        rd(16'h000A, 2'd1, 9'h006, STS);
        rd(16'h0006, 2'd1, 9'h007, 64'h0);
        drain();
    endtask

    task automatic test_scratch;
        wr(16'h0010, 2'd1, 64'hDEAD_BEEF_0123_4567);
        rd(16'h0010, 2'd0, 9'h010, 64'h0123_4567);
        rd(16'h0011, 2'd0, 9'h011, 64'hDEAD_BEEF);
        rd(16'h000E, 2'd1, 9'h012, 64'h1);
        idle(1);
        n_cmp++;
        if (csr_ctrl !== 64'hDEAD_BEEF_0123_4567) begin
            n_err++;
            $display("FAIL csr_ctrl: got %h, want DEADBEEF01234567", csr_ctrl);
        end
        wr(16'h0011, 2'd1, 64'h1111_2222_3333_4444);
        wr(16'h0018, 2'd1, 64'h5555_6666_7777_8888);
        wr(16'h0000, 2'd1, 64'h9999_9999_9999_9999);
        rd(16'h0010, 2'd1, 9'h013, 64'hDEAD_BEEF_0123_4567);
        rd(16'h0018, 2'd1, 9'h014, 64'h0);
        rd(16'h0000, 2'd1, 9'h015, DFH);
        rd(16'h000E, 2'd1, 9'h016, 64'h1);
        drain();
    endtask

    task automatic test_same_cycle;
        req(1'b1, 1'b1, 16'h0013, 2'd0, 9'h020, 64'h0000_0000_A5A5_A5A5, 64'h0);
        rd(16'h0012, 2'd1, 9'h021, 64'hA5A5_A5A5_0000_0000);
        rd(16'h000E, 2'd1, 9'h022, 64'h2);
        drain();
    endtask

    task automatic test_back_to_back;
        logic [15:0] addrs [16] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h000A, 16'h0010, 16'h0012,
                                    16'h0014, 16'h0018, 16'h0100, 16'hFFFE, 16'h0011, 16'h0013, 16'h0001, 16'h0003};
        logic [1:0]  lens  [16] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                                    2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0};
        logic [63:0] exps  [16] = '{DFH, ID[63:0], ID[127:64], 64'h0, 64'h0, STS, 64'hDEAD_BEEF_0123_4567,
                                    64'hA5A5_A5A5_0000_0000, 64'h0, 64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF,
                                    64'hA5A5_A5A5, 64'h0, {32'h0, ID[63:32]}};
        for (int i = 0; i < 16; i++) rd(addrs[i], lens[i], 9'(i), exps[i]);
        drain();
    endtask

    task automatic test_reset_midflight;
        int seen;
        seen = n_rsp;
        @(negedge clk);
        bus.mmio_rd_valid = 1'b1;
        bus.mmio_addr     = 16'h0000;
        bus.mmio_len      = 2'd1;
        bus.mmio_tid      = 9'h055;
        @(negedge clk);
        bus.mmio_rd_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (csr_ctrl !== 64'h0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %h, want 0", csr_ctrl);
        end
        rd(16'h000C, 2'd1, 9'h060, 64'h0);
        rst = 1'b0;
        rd(16'h000C, 2'd1, 9'h061, 64'h1);
        rd(16'h000E, 2'd1, 9'h062, 64'h0);
        rd(16'h0010, 2'd1, 9'h063, 64'h0);
        drain();
        n_cmp++;
        if (n_rsp - seen !== 4) begin
            n_err++;
            $display("FAIL reset_drop: got %0d responses, want 4", n_rsp - seen);
        end
    endtask

    task automatic test_err_log;
`ifdef MMIO_ERR_LOG_EN
        wr(16'h0020, 2'd1, 64'h0);
        rd(16'h0100, 2'd1, 9'h070, 64'h0);
        rd(16'h0100, 2'd1, 9'h071, 64'h0);
        rd(16'h0100, 2'd0, 9'h072, 64'h0);
        rd(16'h0020, 2'd1, 9'h073, 64'h0003_0000_0000_0100);
        wr(16'h0020, 2'd0, 64'h0);
        rd(16'h0020, 2'd1, 9'h074, 64'h0);
`else
        wr(16'h0020, 2'd1, 64'h1234);
        rd(16'h0020, 2'd1, 9'h070, 64'h0);
        rd(16'h0100, 2'd1, 9'h071, 64'h0);
        rd(16'h0020, 2'd1, 9'h072, 64'h0);
`endif
        drain();
    endtask

    initial begin
        test_reset();
        test_ro_regs();
        test_scratch();
        test_same_cycle();
        test_back_to_back();
        test_reset_midflight();
        test_err_log();
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
